// File: rtl/trigger_capture_if.sv
// -----------------------------------------------------------------------------
// trigger_capture_if
// Bundles the event/poll inputs and the snapshot outputs of trigger_capture.
//   i_event_in     : event sources from user logic
//   i_update       : single-cycle host poll strobe, closes the capture window
//   i_cnt_addr     : selects the snapshot counter shown on o_cnt_data
//   o_trig_word    : events seen at least once in the last closed window
//   o_overrun_word : events seen more than once in the last closed window
//   o_trig_valid   : one-cycle pulse when a new snapshot is published
//   o_cnt_data     : snapshot count for bit i_cnt_addr
//   o_pending      : OR of the current-window sticky flags
// master = event source / host side, slave = trigger_capture.
// -----------------------------------------------------------------------------
interface trigger_capture_if #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 4
);
    logic [WIDTH-1:0]  i_event_in;
    logic              i_update;
    logic [ADDR_W-1:0] i_cnt_addr;
    logic [WIDTH-1:0]  o_trig_word;
    logic [WIDTH-1:0]  o_overrun_word;
    logic              o_trig_valid;
    logic [CNT_W-1:0]  o_cnt_data;
    logic              o_pending;

    modport master (
        output i_event_in, i_update, i_cnt_addr,
        input  o_trig_word, o_overrun_word, o_trig_valid, o_cnt_data, o_pending
    );

    modport slave (
        input  i_event_in, i_update, i_cnt_addr,
        output o_trig_word, o_overrun_word, o_trig_valid, o_cnt_data, o_pending
    );
endinterface

// File: rtl/trigger_capture.sv
// -----------------------------------------------------------------------------
// trigger_capture
// Captures event strobes into sticky per-bit flags and saturating per-bit
// counters. Each poll strobe publishes the window (flags, counts, overrun)
// into a snapshot register set and starts a fresh window.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : trigger_capture_if slave (events, poll, count address, snapshot)
// Parameters: WIDTH event bits, CNT_W counter width, EDGE (1 = rising-edge
// qualification, 0 = level), ADDR_W = clog2(WIDTH).
// -----------------------------------------------------------------------------
module trigger_capture #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter int EDGE   = 1,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    trigger_capture_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_acc_flag;
    logic [CNT_W-1:0] r_acc_cnt  [WIDTH];
    logic [CNT_W-1:0] r_snap_cnt [WIDTH];
    logic [WIDTH-1:0] r_trig_word;
    logic [WIDTH-1:0] r_overrun_word;
    logic             r_trig_valid;
    logic [CNT_W-1:0] r_cnt_data;

    logic [WIDTH-1:0] w_evt;
    logic [CNT_W-1:0] w_cnt_sel;

    // History resets to all ones so a level already high at reset release
    // does not look like a rising edge.
    assign w_evt = (EDGE != 0) ? (bus.i_event_in & ~r_prev) : bus.i_event_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '1;
        end else begin
            r_prev <= bus.i_event_in;
        end
    end

    // Accumulate / snapshot swap. An event coincident with the poll strobe
    // seeds the new window rather than the one being published.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_flag     <= '0;
            r_trig_word    <= '0;
            r_overrun_word <= '0;
            r_trig_valid   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_acc_cnt[i]  <= '0;
                r_snap_cnt[i] <= '0;
            end
        end else if (bus.i_update) begin
            r_trig_word  <= r_acc_flag;
            r_acc_flag   <= w_evt;
            r_trig_valid <= 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                r_snap_cnt[i]     <= r_acc_cnt[i];
                r_overrun_word[i] <= (r_acc_cnt[i] > CNT_W'(1));
                r_acc_cnt[i]      <= w_evt[i] ? CNT_W'(1) : '0;
            end
        end else begin
            r_acc_flag   <= r_acc_flag | w_evt;
            r_trig_valid <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_evt[i] && (r_acc_cnt[i] != CNT_MAX)) begin
                    r_acc_cnt[i] <= r_acc_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Decoder-style mux: addresses with no matching bit fall through to 0.
    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.i_cnt_addr == ADDR_W'(i)) begin
                w_cnt_sel = r_snap_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_data <= '0;
        end else begin
            r_cnt_data <= w_cnt_sel;
        end
    end

    assign bus.o_trig_word    = r_trig_word;
    assign bus.o_overrun_word = r_overrun_word;
    assign bus.o_trig_valid   = r_trig_valid;
    assign bus.o_cnt_data     = r_cnt_data;
    assign bus.o_pending      = |r_acc_flag;
endmodule
